stat_accum_ctrl: RTL

Sequencer for the histogram statistic accumulator in the PCMA detector. It runs one measurement frame: clear the histogram, pass exactly N CORDIC samples into it, flush the accumulator's pipeline, then hold the max-search request until the accumulator reports a result. It returns the winning bin index over a valid/ready interface and supports single-shot and continuous operation, with a timeout guard on the search.

---
 rtl/stat_accum_ctrl_pkg.sv | 20 ++
 rtl/stat_frame_cnt.sv | 30 +++
 rtl/stat_accum_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/stat_accum_ctrl_pkg.sv
// Shared definitions for the histogram statistic sequencer: state encoding and
// default sizing common with the accumulator.
package stat_accum_ctrl_pkg;

    localparam int DATA_WIDTH_DEF      = 16;
    localparam int BOUND_NUM_WIDTH_DEF = 5;
    localparam int CNT_WIDTH_DEF       = 16;
    localparam int FLUSH_CYCLES_DEF    = 2;
    localparam int SEARCH_TIMEOUT_DEF  = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_SEARCH = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/stat_frame_cnt.sv
// Loadable down-counter that saturates at zero; terminal count flags zero.
// Shared by the sample, flush and search-timeout phases of a frame.
module stat_frame_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/stat_accum_ctrl.sv
// Frame sequencer for the histogram statistic accumulator: clear, gate N
// samples, flush, run the max search and hand back the winning bin.
//
// state  | meaning
// IDLE   | waiting for start_i
// CLEAR  | one-cycle clear pulse, sample counter loaded with N
// ACCUM  | gating samples until N accepted
// FLUSH  | letting the accumulator pipeline drain
// SEARCH | max search requested, timeout running
// DONE   | result offered until handshake
module stat_accum_ctrl
    import stat_accum_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int BOUND_NUM_WIDTH = BOUND_NUM_WIDTH_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
    parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF,
    parameter int SEARCH_TIMEOUT  = SEARCH_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic                       cont_i,
    input  logic [CNT_WIDTH-1:0]       num_points_i,
    input  logic                       data_val_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    output logic                       acc_clear_o,
    output logic                       acc_val_o,
    output logic [DATA_WIDTH-1:0]      acc_data_o,
    output logic                       acc_search_o,
    input  logic                       acc_done_i,
    input  logic [BOUND_NUM_WIDTH-1:0] acc_max_i,
    output logic                       res_val_o,
    input  logic                       res_ready_i,
    output logic [BOUND_NUM_WIDTH-1:0] res_max_o,
    output logic                       busy_o,
    output logic                       err_timeout_o
);

    // Counter reaches zero on the last cycle of each timed phase.
    localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD   = CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(SEARCH_TIMEOUT - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_cont;
    logic [CNT_WIDTH-1:0]       r_num;
    logic                       r_err;
    logic [BOUND_NUM_WIDTH-1:0] r_res_max;
    logic                       r_acc_val;
    logic [DATA_WIDTH-1:0]      r_acc_data;

    logic                       w_cnt_load;
    logic [CNT_WIDTH-1:0]       w_cnt_load_val;
    logic                       w_cnt_dec;
    logic [CNT_WIDTH-1:0]       w_cnt;
    logic                       w_cnt_tc;
    logic                       w_accept;
    logic                       w_timeout;

    stat_frame_cnt #(.W(CNT_WIDTH)) u_frame_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_tc       (w_cnt_tc)
    );

    assign w_accept = (r_state == ST_ACCUM) && data_val_i && !w_cnt_tc;

    always_comb begin
        w_next         = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_cnt_load     = 1'b1;
                w_cnt_load_val = r_num;
                w_next         = ST_ACCUM;
            end
            ST_ACCUM: begin
                w_cnt_dec = w_accept;
                if (w_accept && (w_cnt == CNT_WIDTH'(1))) begin
                    w_next         = ST_FLUSH;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_tc) begin
                    w_next         = ST_SEARCH;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = TIMEOUT_LOAD;
                end
            end
            ST_SEARCH: begin
                w_cnt_dec = 1'b1;
                // A result arriving on the final cycle still wins over the timeout.
                if (acc_done_i) begin
                    w_next = ST_DONE;
                end else if (w_cnt_tc) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (res_ready_i) w_next = r_cont ? ST_CLEAR : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cont     <= 1'b0;
            r_num      <= '0;
            r_err      <= 1'b0;
            r_res_max  <= '0;
            r_acc_val  <= 1'b0;
            r_acc_data <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start_i) begin
                r_cont <= cont_i;
                r_num  <= (num_points_i == '0) ? CNT_WIDTH'(1) : num_points_i;
                r_err  <= 1'b0;
            end
            if (w_timeout) r_err <= 1'b1;
            if ((r_state == ST_SEARCH) && acc_done_i) r_res_max <= acc_max_i;
            r_acc_val <= w_accept;
            if (w_accept) r_acc_data <= data_i;
        end
    end

    assign acc_clear_o   = (r_state == ST_CLEAR);
    assign acc_search_o  = (r_state == ST_SEARCH);
    assign res_val_o     = (r_state == ST_DONE);
    assign busy_o        = (r_state != ST_IDLE);
    assign acc_val_o     = r_acc_val;
    assign acc_data_o    = r_acc_data;
    assign res_max_o     = r_res_max;
    assign err_timeout_o = r_err;

endmodule
